// File: rtl/ma_stage.sv
// Memory-access pipeline stage: issues load/store requests to the data bus,
// stalls the front end until the access completes or times out, and feeds the MA/WB registers.
module ma_stage #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_Ma,
  input  logic [31:0] alu_out_Ma,
  input  logic [31:0] rs2_Ma,
  input  logic [31:0] inst_Ma,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [31:0] alu_out_Ma_fb,
  output logic [31:0] pc_Wb,
  output logic [31:0] alu_out_Wb,
  output logic [31:0] mem_data_Wb,
  output logic [31:0] inst_Wb,
  output logic        misalign_Wb,
  output logic        mem_err_Wb
);

  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   pcWb_q, pcWb_d, aluWb_q, aluWb_d, memWb_q, memWb_d, instWb_q, instWb_d;
  logic          misWb_q, misWb_d, errWb_q, errWb_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [1:0]  byteOff;
  logic        isLoad, isStore, isMem, misaligned, timeout;
  logic        reqActive, stallActive;
  logic [3:0]  storeBe;
  logic [31:0] storeData, lane, loadData;

  assign opcode     = inst_Ma[6:0];
  assign funct3     = inst_Ma[14:12];
  assign byteOff    = alu_out_Ma[1:0];
  assign isLoad     = (opcode == 7'b0000011);
  assign isStore    = (opcode == 7'b0100011);
  assign isMem      = isLoad | isStore;
  // funct3[1] set covers word and the unsupported 011/110/111 loads, all word-sized
  assign misaligned = isMem && (((funct3[1:0] == 2'b01) && byteOff[0]) ||
                                (funct3[1] && (byteOff != 2'b00)));
  assign timeout    = (state_q == BUSY) && !dmem_ack && (cnt_q == CW'(MAX_WAIT));

  always_comb begin
    storeBe   = 4'b1111;
    storeData = rs2_Ma;
    case (funct3[1:0])
      2'b00: begin
        storeBe   = 4'b0001 << byteOff;
        storeData = {4{rs2_Ma[7:0]}};
      end
      2'b01: begin
        storeBe   = 4'b0011 << byteOff;
        storeData = {2{rs2_Ma[15:0]}};
      end
      default: ;
    endcase
  end

  assign lane = dmem_rdata >> {byteOff, 3'b000};

  always_comb begin
    case (funct3)
      3'b000:  loadData = {{24{lane[7]}}, lane[7:0]};
      3'b100:  loadData = {24'b0, lane[7:0]};
      3'b001:  loadData = {{16{lane[15]}}, lane[15:0]};
      3'b101:  loadData = {16'b0, lane[15:0]};
      default: loadData = lane;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    reqActive   = 1'b0;
    stallActive = 1'b0;
    pcWb_d      = pc_Ma;
    aluWb_d     = alu_out_Ma;
    instWb_d    = inst_Ma;
    memWb_d     = '0;
    misWb_d     = 1'b0;
    errWb_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (misaligned) begin
          instWb_d = NOP;
          misWb_d  = 1'b1;
        end else if (isMem) begin
          reqActive   = 1'b1;
          stallActive = 1'b1;
          state_d     = BUSY;
          cnt_d       = '0;
          pcWb_d      = '0;
          aluWb_d     = '0;
          instWb_d    = NOP;
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          reqActive = 1'b1;
          state_d   = IDLE;
          if (isLoad) memWb_d = loadData;
        end else if (timeout) begin
          state_d = IDLE;
          errWb_d = 1'b1;
        end else begin
          reqActive   = 1'b1;
          stallActive = 1'b1;
          cnt_d       = cnt_q + CW'(1);
          pcWb_d      = '0;
          aluWb_d     = '0;
          instWb_d    = NOP;
        end
      end
    endcase
  end

  // Gating with rst_n drops the bus request and stall the moment reset asserts
  assign dmem_req      = rst_n & reqActive;
  assign stall         = rst_n & stallActive;
  assign dmem_we       = dmem_req & isStore;
  assign dmem_be       = (dmem_req & isStore) ? storeBe : 4'b0000;
  assign dmem_addr     = {alu_out_Ma[31:2], 2'b00};
  assign dmem_wdata    = storeData;
  assign alu_out_Ma_fb = alu_out_Ma;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pcWb_q   <= '0;
      aluWb_q  <= '0;
      memWb_q  <= '0;
      instWb_q <= NOP;
      misWb_q  <= 1'b0;
      errWb_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pcWb_q   <= pcWb_d;
      aluWb_q  <= aluWb_d;
      memWb_q  <= memWb_d;
      instWb_q <= instWb_d;
      misWb_q  <= misWb_d;
      errWb_q  <= errWb_d;
    end
  end

  assign pc_Wb       = pcWb_q;
  assign alu_out_Wb  = aluWb_q;
  assign mem_data_Wb = memWb_q;
  assign inst_Wb     = instWb_q;
  assign misalign_Wb = misWb_q;
  assign mem_err_Wb  = errWb_q;

endmodule

// File: tb/tb_ma_stage.sv
// Self-checking bench for ma_stage: directed vector table, randomized transactions
// against a transaction-level reference model, and a reset-during-access sequence.
module tb_ma_stage;

  localparam int MAX_WAIT = 15;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, rst_n;
  logic [31:0] pc_Ma, alu_out_Ma, rs2_Ma, inst_Ma;
  logic        dmem_req, dmem_we, dmem_ack, stall;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, alu_out_Ma_fb;
  logic [3:0]  dmem_be;
  logic [31:0] pc_Wb, alu_out_Wb, mem_data_Wb, inst_Wb;
  logic        misalign_Wb, mem_err_Wb;

  int checks = 0;
  int errors = 0;
  int curTxn = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] expMem;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
    logic        expMis;
    logic        expErr;
  } vec_t;

  ma_stage #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .pc_Ma(pc_Ma), .alu_out_Ma(alu_out_Ma), .rs2_Ma(rs2_Ma), .inst_Ma(inst_Ma),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .alu_out_Ma_fb(alu_out_Ma_fb),
    .pc_Wb(pc_Wb), .alu_out_Wb(alu_out_Wb), .mem_data_Wb(mem_data_Wb), .inst_Wb(inst_Wb),
    .misalign_Wb(misalign_Wb), .mem_err_Wb(mem_err_Wb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (txn %0d): got %h expected %h", name, curTxn, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] addr,
                               input logic [31:0] rs2, input logic [31:0] inst,
                               input logic [31:0] rdata);
    pc_Ma      = pc;
    alu_out_Ma = addr;
    rs2_Ma     = rs2;
    inst_Ma    = inst;
    dmem_rdata = rdata;
  endtask

  function automatic int widthOf(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [3:0] modelBe(input logic [2:0] f3, input logic [31:0] addr);
    int n = widthOf(f3);
    int off = int'(addr % 4);
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] rs2);
    int n = widthOf(f3);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = rs2[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] rdata);
    int n = widthOf(f3);
    int unsigned off = addr % 4;
    int unsigned lane = rdata >> (8 * off);
    int unsigned val;
    if (n == 4) return lane;
    val = lane % (32'd1 << (8 * n));
    if ((f3 == 3'b000 || f3 == 3'b001) && val >= (32'd1 << (8 * n - 1)))
      val = val - (32'd1 << (8 * n));
    return val;
  endfunction

  function automatic vec_t mkVec(input logic [31:0] inst, input logic [31:0] pc,
                                 input logic [31:0] addr, input logic [31:0] rs2,
                                 input logic [31:0] rdata, input int delay,
                                 input logic [31:0] expMem, input logic [3:0] expBe,
                                 input logic [31:0] expWdata, input logic expMis,
                                 input logic expErr);
    vec_t v;
    v.inst = inst; v.pc = pc; v.addr = addr; v.rs2 = rs2; v.rdata = rdata;
    v.delay = delay; v.expMem = expMem; v.expBe = expBe; v.expWdata = expWdata;
    v.expMis = expMis; v.expErr = expErr;
    return v;
  endfunction

  task automatic checkBus(input vec_t v, input bit isStore);
    checkOutput("addr", dmem_addr, {v.addr[31:2], 2'b00});
    checkOutput("we", 32'(dmem_we), 32'(isStore));
    checkOutput("be", 32'(dmem_be), isStore ? 32'(v.expBe) : 32'd0);
    if (isStore) checkOutput("wdata", dmem_wdata, v.expWdata);
  endtask

  // Entered and left at a falling clock edge
  task automatic runTxn(input vec_t v);
    bit isLoad, isStore;
    int stallCount, expStalls;
    isLoad  = (v.inst[6:0] == 7'b0000011);
    isStore = (v.inst[6:0] == 7'b0100011);
    applyStimulus(v.pc, v.addr, v.rs2, v.inst, v.rdata);
    dmem_ack = 1'b0;
    #1;
    checkOutput("fwd", alu_out_Ma_fb, v.addr);
    if (!(isLoad || isStore) || v.expMis) begin
      checkOutput("passStall", 32'(stall), 32'd0);
      checkOutput("passReq", 32'(dmem_req), 32'd0);
      @(negedge clk);
      checkOutput("passInst", inst_Wb, v.expMis ? NOP : v.inst);
      checkOutput("passMis", 32'(misalign_Wb), 32'(v.expMis));
      checkOutput("passErr", 32'(mem_err_Wb), 32'd0);
      checkOutput("passMem", mem_data_Wb, 32'd0);
      if (!v.expMis) begin
        checkOutput("passAlu", alu_out_Wb, v.addr);
        checkOutput("passPc", pc_Wb, v.pc);
      end
    end else begin
      checkOutput("issueReq", 32'(dmem_req), 32'd1);
      checkOutput("issueStall", 32'(stall), 32'd1);
      checkBus(v, isStore);
      stallCount = stall ? 1 : 0;
      for (int k = 0; k <= MAX_WAIT; k++) begin
        @(negedge clk);
        checkOutput("bubbleInst", inst_Wb, NOP);
        checkOutput("bubbleMem", mem_data_Wb, 32'd0);
        dmem_ack = (k == v.delay);
        #1;
        if (stall) stallCount++;
        if (dmem_ack) begin
          checkOutput("ackReq", 32'(dmem_req), 32'd1);
          checkOutput("ackStall", 32'(stall), 32'd0);
          checkBus(v, isStore);
          break;
        end else if (k == MAX_WAIT) begin
          checkOutput("toReq", 32'(dmem_req), 32'd0);
          checkOutput("toStall", 32'(stall), 32'd0);
          break;
        end else begin
          checkOutput("waitReq", 32'(dmem_req), 32'd1);
          checkOutput("waitStall", 32'(stall), 32'd1);
          checkBus(v, isStore);
        end
      end
      @(negedge clk);
      dmem_ack = 1'b0;
      expStalls = (v.delay > MAX_WAIT) ? MAX_WAIT + 1 : v.delay + 1;
      checkOutput("stallCycles", 32'(stallCount), 32'(expStalls));
      checkOutput("wbPc", pc_Wb, v.pc);
      checkOutput("wbAlu", alu_out_Wb, v.addr);
      checkOutput("wbInst", inst_Wb, v.inst);
      checkOutput("wbMem", mem_data_Wb, v.expMem);
      checkOutput("wbErr", 32'(mem_err_Wb), 32'(v.expErr));
      checkOutput("wbMis", 32'(misalign_Wb), 32'd0);
    end
  endtask

  vec_t tbl[16];

  initial begin
    vec_t rv;
    logic [2:0] f3;
    int n, r;
    bit isL;

    tbl[0]  = mkVec(32'h002081B3, 32'h100, 32'h0000_1234, 0, 0, 0, 0, 4'h0, 0, 1'b0, 1'b0);
    tbl[1]  = mkVec(32'h00008083, 32'h104, 32'h0000_1003, 0, 32'h80FF_FFFF, 3,
                    32'hFFFF_FF80, 4'h0, 0, 1'b0, 1'b0);
    tbl[2]  = mkVec(32'h00209023, 32'h108, 32'h0000_2002, 32'hAAAA_5678, 0, 2,
                    0, 4'b1100, 32'h5678_5678, 1'b0, 1'b0);
    tbl[3]  = mkVec(32'h0000A083, 32'h10C, 32'h0000_0001, 0, 0, 0, 0, 4'h0, 0, 1'b1, 1'b0);
    tbl[4]  = mkVec(32'h0000A083, 32'h110, 32'h0000_3000, 0, 32'h1111_2222, 1000,
                    0, 4'h0, 0, 1'b0, 1'b1);
    tbl[5]  = mkVec(32'h0000C083, 32'h114, 32'h0000_1001, 0, 32'h1234_80AB, 0,
                    32'h0000_0080, 4'h0, 0, 1'b0, 1'b0);
    tbl[6]  = mkVec(32'h00009083, 32'h118, 32'h0000_1002, 0, 32'h8001_0000, 1,
                    32'hFFFF_8001, 4'h0, 0, 1'b0, 1'b0);
    tbl[7]  = mkVec(32'h0000D083, 32'h11C, 32'h0000_1002, 0, 32'h8001_0000, 0,
                    32'h0000_8001, 4'h0, 0, 1'b0, 1'b0);
    tbl[8]  = mkVec(32'h0000A083, 32'h120, 32'h0000_1004, 0, 32'hDEAD_BEEF, MAX_WAIT,
                    32'hDEAD_BEEF, 4'h0, 0, 1'b0, 1'b0);
    tbl[9]  = mkVec(32'h00208023, 32'h124, 32'h0000_2001, 32'h1234_56C3, 0, 0,
                    0, 4'b0010, 32'hC3C3_C3C3, 1'b0, 1'b0);
    tbl[10] = mkVec(32'h0020A023, 32'h128, 32'h0000_2008, 32'hCAFE_F00D, 0, 1,
                    0, 4'b1111, 32'hCAFE_F00D, 1'b0, 1'b0);
    tbl[11] = mkVec(32'h00009083, 32'h12C, 32'h0000_1001, 0, 0, 0, 0, 4'h0, 0, 1'b1, 1'b0);
    tbl[12] = mkVec(32'h0000B083, 32'h130, 32'h0000_1006, 0, 0, 0, 0, 4'h0, 0, 1'b1, 1'b0);
    tbl[13] = mkVec(32'h0000B083, 32'h134, 32'h0000_1008, 0, 32'h1122_3344, 0,
                    32'h1122_3344, 4'h0, 0, 1'b0, 1'b0);
    tbl[14] = mkVec(32'h0020A023, 32'h138, 32'h0000_2002, 32'h1, 0, 0, 0, 4'h0, 0, 1'b1, 1'b0);
    tbl[15] = mkVec(NOP, 32'h13C, 32'hFFFF_FFFF, 0, 0, 0, 0, 4'h0, 0, 1'b0, 1'b0);

    rst_n    = 1'b1;
    dmem_ack = 1'b0;
    applyStimulus(0, 0, 0, NOP, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstInst", inst_Wb, NOP);
    checkOutput("rstPc", pc_Wb, 32'd0);
    checkOutput("rstAlu", alu_out_Wb, 32'd0);
    checkOutput("rstMem", mem_data_Wb, 32'd0);
    checkOutput("rstFlags", {30'b0, misalign_Wb, mem_err_Wb}, 32'd0);
    checkOutput("rstReq", 32'(dmem_req), 32'd0);
    checkOutput("rstStall", 32'(stall), 32'd0);
    checkOutput("rstBe", 32'(dmem_be), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      curTxn = i;
      runTxn(tbl[i]);
    end

    for (int i = 0; i < 60; i++) begin
      curTxn = 100 + i;
      r = $urandom_range(0, 9);
      rv.pc  = $urandom;
      rv.rs2 = $urandom;
      rv.rdata = $urandom;
      rv.addr = $urandom;
      rv.delay = ($urandom_range(0, 9) == 0) ? MAX_WAIT + 1 : $urandom_range(0, 3);
      rv.expBe = 4'h0; rv.expWdata = 0; rv.expMem = 0; rv.expMis = 1'b0; rv.expErr = 1'b0;
      if (r < 2) begin
        rv.inst = ($urandom & 32'hFFFF_FF80) | ((r == 0) ? 32'h33 : 32'h13);
      end else begin
        isL = (r < 7);
        if (isL) begin
          case ($urandom_range(0, 5))
            0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010;
            3: f3 = 3'b100; 4: f3 = 3'b101; default: f3 = 3'b011;
          endcase
        end else begin
          f3 = 3'($urandom_range(0, 2));
        end
        n = widthOf(f3);
        if ($urandom_range(0, 1) == 1) rv.addr = rv.addr & ~(32'(n) - 32'd1);
        rv.inst = ($urandom & 32'hFFFF_8F80) | {17'b0, f3, 12'b0} | (isL ? 32'h03 : 32'h23);
        rv.expMis = (rv.addr % n) != 0;
        if (!rv.expMis) begin
          rv.expErr = (rv.delay > MAX_WAIT);
          if (isL && !rv.expErr) rv.expMem = modelLoad(f3, rv.addr, rv.rdata);
          if (!isL) begin
            rv.expBe    = modelBe(f3, rv.addr);
            rv.expWdata = modelWdata(f3, rv.rs2);
          end
        end
      end
      runTxn(rv);
    end

    // Reset asserted while an access is outstanding, then a late ack after release
    curTxn = 200;
    applyStimulus(32'h500, 32'h4000, 0, 32'h0000A083, 32'h5555_5555);
    dmem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("midBusyReq", 32'(dmem_req), 32'd1);
    checkOutput("midBusyStall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rbReq", 32'(dmem_req), 32'd0);
    checkOutput("rbStall", 32'(stall), 32'd0);
    checkOutput("rbInst", inst_Wb, NOP);
    checkOutput("rbPc", pc_Wb, 32'd0);
    applyStimulus(32'h600, 32'h55, 0, 32'h002081B3, 32'h5555_5555);
    dmem_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("lateAckStall", 32'(stall), 32'd0);
    checkOutput("lateAckReq", 32'(dmem_req), 32'd0);
    @(negedge clk);
    checkOutput("lateAckInst", inst_Wb, 32'h002081B3);
    checkOutput("lateAckAlu", alu_out_Wb, 32'h55);
    checkOutput("lateAckMem", mem_data_Wb, 32'd0);
    checkOutput("lateAckErr", 32'(mem_err_Wb), 32'd0);
    dmem_ack = 1'b0;

    curTxn = 201;
    runTxn(tbl[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ma_stage.md
MA_STAGE -- requirements
Module: ma_stage

Interface
REQ-001 Parameter MAX_WAIT, default 15: maximum BUSY cycles waiting for dmem_ack before timeout.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 pc_Ma  in  32  PC of the instruction in MA, from the EX pipeline register.
REQ-005 alu_out_Ma  in  32  effective address or ALU result from EX.
REQ-006 rs2_Ma  in  32  store data from EX.
REQ-007 inst_Ma  in  32  instruction in MA; opcode [6:0], funct3 [14:12].
REQ-008 dmem_req  out  1  data-memory request.
REQ-009 dmem_we  out  1  1 = write, 0 = read.
REQ-010 dmem_addr  out  32  word address, alu_out_Ma with [1:0] forced to 0.
REQ-011 dmem_wdata  out  32  lane-replicated store data.
REQ-012 dmem_be  out  4  byte enables; 0000 on reads.
REQ-013 dmem_ack  in  1  memory completion; read data valid in the same cycle.
REQ-014 dmem_rdata  in  32  read word.
REQ-015 stall  out  1  freezes PC/IF/ID/EX pipeline registers while high.
REQ-016 alu_out_Ma_fb  out  32  combinational copy of alu_out_Ma for EX forwarding.
REQ-017 pc_Wb, alu_out_Wb, mem_data_Wb, inst_Wb  out  32 each  MA/WB pipeline registers.
REQ-018 misalign_Wb, mem_err_Wb  out  1 each  registered fault flags travelling with inst_Wb.

Function
REQ-019 Mem op: opcode 0000011 (load) or 0100011 (store); every other opcode passes through without a bus access.
REQ-020 Misaligned: halfword (funct3[1:0]=01) with addr[0]=1, or word (funct3[1:0]=10) with addr[1:0]!=00; no bus access, no stall, and WB loads NOP 0x00000013 with misalign_Wb=1.
REQ-021 FSM states are IDLE and BUSY.
REQ-022 IDLE with an aligned mem op: dmem_req=1 and stall=1 combinationally; next state BUSY; dmem_ack is ignored in IDLE.
REQ-023 BUSY: dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be hold stable; stall=1 until completion.
REQ-024 BUSY with dmem_ack=1: stall=0, WB registers load the completed op, next state IDLE; minimum latency is 2 cycles (1 stall cycle).
REQ-025 Wait counter: cleared on IDLE->BUSY, incremented in each BUSY cycle without ack.
REQ-026 BUSY without ack on the cycle the counter equals MAX_WAIT: dmem_req drops, stall=0, WB loads the op with mem_data_Wb=0 and mem_err_Wb=1, next state IDLE.
REQ-027 While stall=1 and not completing, WB loads a bubble: inst_Wb=0x00000013, flags 0, other WB registers 0.
REQ-028 Non-stalled pass-through: pc_Wb<=pc_Ma, alu_out_Wb<=alu_out_Ma, inst_Wb<=inst_Ma, mem_data_Wb<=0.
REQ-029 Store enables: SB be=0001<<addr[1:0], wdata={4{rs2[7:0]}}; SH be=0011<<addr[1:0], wdata={2{rs2[15:0]}}; SW be=1111, wdata=rs2.
REQ-030 Load lane is dmem_rdata shifted right by 8*addr[1:0].
REQ-031 Load extension: LB sign-extends bits[7:0]; LBU zero-extends bits[7:0]; LH sign-extends bits[15:0]; LHU zero-extends bits[15:0]; LW passes 32 bits.
REQ-032 Stores write mem_data_Wb=0; alu_out_Wb carries the address for all mem ops.
REQ-033 Unsupported load funct3 (011, 110, 111) is treated as LW width and alignment.

Reset
REQ-034 rst_n low asynchronously forces: state IDLE, counter 0, dmem_req=0, dmem_we=0, dmem_be=0000, stall=0, pc_Wb/alu_out_Wb/mem_data_Wb=0, inst_Wb=0x00000013, flags 0.
REQ-035 Reset asserted in BUSY abandons the access immediately; any late dmem_ack after release is ignored in IDLE.

Verification
REQ-036 ADD passes through: inst_Ma=ADD, alu_out_Ma=0x1234 -> next edge alu_out_Wb=0x1234, stall never high.
REQ-037 LB sign extension: LB addr 0x1003, ack after 3 BUSY cycles, rdata=0x80FF_FF_FF -> stall high 4 cycles, mem_data_Wb=0xFFFFFF80, dmem_addr=0x1000.
REQ-038 Store lane replication: SH addr 0x2002, rs2=0xAAAA5678 -> dmem_we=1, be=1100, wdata=0x56785678 held stable until ack.
REQ-039 Misaligned word: LW addr 0x0001 -> dmem_req never asserted, inst_Wb=0x00000013, misalign_Wb=1.
REQ-040 Timeout: LW with ack held 0 -> after MAX_WAIT+1 stall cycles mem_err_Wb=1, mem_data_Wb=0, FSM returns to IDLE.
REQ-041 Reset in BUSY: rst_n low mid-BUSY -> dmem_req=0 and stall=0 immediately; ack after release produces no WB update.
